// File: rtl/ctrl_pkg.sv
// Shared control-bundle types and instruction-field constants for the pipelined
// decoder: instrType/opcode codes, the EX control bundle and its reset value.
package ctrl_pkg;

  localparam logic [2:0] T_U = 3'b001;
  localparam logic [2:0] T_J = 3'b010;
  localparam logic [2:0] T_B = 3'b011;
  localparam logic [2:0] T_I = 3'b100;
  localparam logic [2:0] T_S = 3'b101;
  localparam logic [2:0] T_R = 3'b110;

  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef struct packed {
    logic       we_reg;
    logic       pc_control;
    logic [1:0] wd_select;
    logic       alu_bsel;
    logic       alu_asel;
    logic       memory_en;
    logic [1:0] store_size;
    logic       jump;
    logic       branch;
    logic       mul;
  } ctrl_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MUL_WAIT = 2'd2
  } state_t;

  localparam ctrl_t CTRL_RST = '{
    we_reg:     1'b0,
    pc_control: 1'b0,
    wd_select:  2'b00,
    alu_bsel:   1'b0,
    alu_asel:   1'b1,
    memory_en:  1'b0,
    store_size: 2'b11,
    jump:       1'b0,
    branch:     1'b0,
    mul:        1'b0
  };

  function automatic logic [1:0] store_size_of(input logic [2:0] funct3);
    case (funct3)
      3'b000:  store_size_of = 2'b00;
      3'b001:  store_size_of = 2'b01;
      3'b010:  store_size_of = 2'b10;
      default: store_size_of = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of the decode-stage instruction fields into the control
// bundle plus the source-register usage flags needed for hazard detection.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int ENABLE_M = 0
) (
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [2:0] instrType,
  input  logic       funct7_0,
  output ctrl_t      ctrl_o,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o
);

  always_comb begin
    ctrl_o = CTRL_RST;
    unique case (instrType)
      T_U: begin
        ctrl_o.we_reg    = 1'b1;
        ctrl_o.wd_select = 2'b11;
        if (op == OP_AUIPC) begin
          ctrl_o.alu_asel  = 1'b0;
          ctrl_o.wd_select = 2'b00;
        end
      end
      T_J: begin
        ctrl_o.we_reg     = 1'b1;
        ctrl_o.pc_control = 1'b1;
        ctrl_o.wd_select  = 2'b10;
        ctrl_o.alu_asel   = 1'b0;
        ctrl_o.jump       = 1'b1;
      end
      T_B: begin
        ctrl_o.branch     = 1'b1;
        ctrl_o.pc_control = 1'b1;
        ctrl_o.wd_select  = 2'b10;
        ctrl_o.alu_asel   = 1'b0;
      end
      T_I: begin
        if (op == OP_JALR) begin
          ctrl_o.we_reg     = 1'b1;
          ctrl_o.pc_control = 1'b1;
          ctrl_o.wd_select  = 2'b10;
          ctrl_o.jump       = 1'b1;
        end else if (op == OP_LOAD) begin
          ctrl_o.we_reg    = 1'b1;
          ctrl_o.wd_select = 2'b01;
          ctrl_o.memory_en = 1'b1;
        end else if (op == OP_OPIMM) begin
          ctrl_o.we_reg = 1'b1;
        end
      end
      T_S: begin
        ctrl_o.memory_en  = 1'b1;
        ctrl_o.wd_select  = 2'b00;
        ctrl_o.store_size = store_size_of(funct3);
      end
      T_R: begin
        ctrl_o.alu_bsel = 1'b1;
        ctrl_o.we_reg   = !((op == OP_SYSTEM) || (op == OP_FENCE));
        ctrl_o.mul      = (ENABLE_M != 0) && (op == OP_OP) && funct7_0;
      end
      default: ;
    endcase
  end

  // U and J have no rs1 field; only B/S/R read rs2.
  assign uses_rs1_o = (instrType != T_U) && (instrType != T_J);
  assign uses_rs2_o = (instrType == T_B) || (instrType == T_S) || (instrType == T_R);

endmodule

// File: rtl/pipe_controller.sv
// Decode-to-EX pipeline control: registers the decoded bundle into EX, inserts
// load-use bubbles, flushes on redirect and holds during memory/multiply waits.
module pipe_controller
  import ctrl_pkg::*;
#(
  parameter int REGW     = 5,
  parameter int ENABLE_M = 0,
  parameter int MUL_LAT  = 3
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            instr_valid,
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic [2:0]      instrType,
  input  logic            funct7_0,
  input  logic [REGW-1:0] rs1,
  input  logic [REGW-1:0] rs2,
  input  logic [REGW-1:0] rd,
  input  logic            mem_ready,
  input  logic            redirect,
  output logic            stall_fetch,
  output logic            ex_valid,
  output logic            ex_we_reg,
  output logic            ex_pcControl,
  output logic            ex_memory_en,
  output logic            ex_aluBsel,
  output logic            ex_aluAsel,
  output logic            ex_jump,
  output logic            ex_branch,
  output logic            ex_mul,
  output logic [1:0]      ex_wdSelect,
  output logic [1:0]      ex_store_size,
  output logic [REGW-1:0] ex_rd
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  ctrl_t             dec_ctrl;
  logic              uses_rs1;
  logic              uses_rs2;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ex_valid_q, ex_valid_d;
  ctrl_t             ex_ctrl_q, ex_ctrl_d;
  logic [REGW-1:0]   ex_rd_q, ex_rd_d;

  logic              hold;
  logic              hazard;

  ctrl_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .op         (op),
    .funct3     (funct3),
    .instrType  (instrType),
    .funct7_0   (funct7_0),
    .ctrl_o     (dec_ctrl),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2)
  );

  always_comb begin
    hold   = ((state_q == MEM_WAIT) && !mem_ready) ||
             ((state_q == MUL_WAIT) && (cnt_q != '0));
    hazard = ex_valid_q && (ex_ctrl_q.wd_select == 2'b01) && (ex_rd_q != '0) &&
             instr_valid &&
             (((ex_rd_q == rs1) && uses_rs1) || ((ex_rd_q == rs2) && uses_rs2));
    // A redirect kills the decode instruction, so there is nothing to stall for.
    stall_fetch = hold || (!redirect && hazard);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ex_valid_d = ex_valid_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_rd_d    = ex_rd_q;
    if (!hold) begin
      ex_ctrl_d  = dec_ctrl;
      ex_rd_d    = rd;
      ex_valid_d = instr_valid && !redirect && !hazard;
      if (ex_valid_d && dec_ctrl.memory_en) begin
        state_d = MEM_WAIT;
        cnt_d   = '0;
      end else if (ex_valid_d && dec_ctrl.mul && (MUL_LAT > 1)) begin
        state_d = MUL_WAIT;
        cnt_d   = CNT_W'(MUL_LAT - 1);
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else if (state_q == MUL_WAIT) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= CTRL_RST;
      ex_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rd_q    <= ex_rd_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_we_reg     = ex_ctrl_q.we_reg;
  assign ex_pcControl  = ex_ctrl_q.pc_control;
  assign ex_memory_en  = ex_ctrl_q.memory_en;
  assign ex_aluBsel    = ex_ctrl_q.alu_bsel;
  assign ex_aluAsel    = ex_ctrl_q.alu_asel;
  assign ex_jump       = ex_ctrl_q.jump;
  assign ex_branch     = ex_ctrl_q.branch;
  assign ex_mul        = ex_ctrl_q.mul;
  assign ex_wdSelect   = ex_ctrl_q.wd_select;
  assign ex_store_size = ex_ctrl_q.store_size;
  assign ex_rd         = ex_rd_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: one instance without and one with the
// multiply option, driven by the same decode-stage stimulus.
module tb_pipe_controller;

  logic       CLK;
  logic       RST_N;
  logic       instr_valid;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [2:0] instrType;
  logic       funct7_0;
  logic [4:0] rs1, rs2, rd;
  logic       mem_ready;
  logic       redirect;

  logic       a_stall, a_valid, a_we, a_pc, a_mem, a_bsel, a_asel, a_jump, a_branch, a_mul;
  logic [1:0] a_wd, a_ss;
  logic [4:0] a_rd;
  logic       m_stall, m_valid, m_we, m_pc, m_mem, m_bsel, m_asel, m_jump, m_branch, m_mul;
  logic [1:0] m_wd, m_ss;
  logic [4:0] m_rd;

  logic [11:0] a_bundle, m_bundle;
  assign a_bundle = {a_we, a_pc, a_wd, a_bsel, a_asel, a_mem, a_ss, a_jump, a_branch, a_mul};
  assign m_bundle = {m_we, m_pc, m_wd, m_bsel, m_asel, m_mem, m_ss, m_jump, m_branch, m_mul};

  int n_checks = 0;
  int n_fail   = 0;

  pipe_controller #(.REGW(5), .ENABLE_M(0), .MUL_LAT(3)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .instr_valid(instr_valid), .op(op), .funct3(funct3),
    .instrType(instrType), .funct7_0(funct7_0), .rs1(rs1), .rs2(rs2), .rd(rd),
    .mem_ready(mem_ready), .redirect(redirect), .stall_fetch(a_stall),
    .ex_valid(a_valid), .ex_we_reg(a_we), .ex_pcControl(a_pc), .ex_memory_en(a_mem),
    .ex_aluBsel(a_bsel), .ex_aluAsel(a_asel), .ex_jump(a_jump), .ex_branch(a_branch),
    .ex_mul(a_mul), .ex_wdSelect(a_wd), .ex_store_size(a_ss), .ex_rd(a_rd)
  );

  pipe_controller #(.REGW(5), .ENABLE_M(1), .MUL_LAT(4)) u_dut_m (
    .CLK(CLK), .RST_N(RST_N), .instr_valid(instr_valid), .op(op), .funct3(funct3),
    .instrType(instrType), .funct7_0(funct7_0), .rs1(rs1), .rs2(rs2), .rd(rd),
    .mem_ready(mem_ready), .redirect(redirect), .stall_fetch(m_stall),
    .ex_valid(m_valid), .ex_we_reg(m_we), .ex_pcControl(m_pc), .ex_memory_en(m_mem),
    .ex_aluBsel(m_bsel), .ex_aluAsel(m_asel), .ex_jump(m_jump), .ex_branch(m_branch),
    .ex_mul(m_mul), .ex_wdSelect(m_wd), .ex_store_size(m_ss), .ex_rd(m_rd)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input string name, input logic v, input logic [6:0] o,
                       input logic [2:0] f3, input logic [2:0] ty, input logic f7,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    instr_valid = v; op = o; funct3 = f3; instrType = ty; funct7_0 = f7;
    rs1 = s1; rs2 = s2; rd = d;
    $display("[%0t] decode %s v=%0b rd=x%0d rs1=x%0d rs2=x%0d", $time, name, v, d, s1, s2);
  endtask

  initial begin
    RST_N = 1'b0; mem_ready = 1'b1; redirect = 1'b0;
    drive("JAL", 1'b1, 7'b1101111, 3'b000, 3'b010, 1'b0, 5'd0, 5'd0, 5'd1);

    // Reset held for two cycles with a valid JAL at decode
    tick(); tick();
    check("rst_a_valid", a_valid, 0);
    check("rst_a_bundle", a_bundle, 12'h058);
    check("rst_a_rd", a_rd, 0);
    check("rst_a_stall", a_stall, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_bundle", m_bundle, 12'h058);
    check("rst_m_rd", m_rd, 0);
    check("rst_m_stall", m_stall, 0);

    // JAL decode after reset release
    RST_N = 1'b1;
    tick();
    check("jal_valid", a_valid, 1);
    check("jal_bundle", a_bundle, 12'hE1C);  // we pc wd10 asel0 ss11 jump

    // Load-use: LW x5 then ADD x6,x5,x1
    drive("LW x5", 1'b1, 7'b0000011, 3'b010, 3'b100, 1'b0, 5'd1, 5'd0, 5'd5);
    #1 check("lw_stall", a_stall, 0);
    tick();
    check("lw_ex_valid", a_valid, 1);
    check("lw_ex_mem", a_mem, 1);
    check("lw_ex_wd", a_wd, 2'b01);
    check("lw_ex_rd", a_rd, 5);
    drive("ADD x6", 1'b1, 7'b0110011, 3'b000, 3'b110, 1'b0, 5'd5, 5'd1, 5'd6);
    #1 check("lu_stall", a_stall, 1);
    tick();
    check("lu_bubble", a_valid, 0);
    #1 check("lu_stall_clear", a_stall, 0);
    tick();
    check("add_valid", a_valid, 1);
    check("add_rd", a_rd, 6);
    check("add_bsel", a_bsel, 1);
    check("add_we", a_we, 1);

    // SW word with three mem_ready=0 cycles; redirect during hold is ignored
    drive("SW", 1'b1, 7'b0100011, 3'b010, 3'b101, 1'b0, 5'd2, 5'd3, 5'd0);
    mem_ready = 1'b0;
    #1 check("sw_enter_stall", a_stall, 0);
    tick();
    drive("ADDI x7", 1'b1, 7'b0010011, 3'b000, 3'b100, 1'b0, 5'd0, 5'd0, 5'd7);
    for (int i = 0; i < 3; i++) begin
      redirect = (i == 1);
      check($sformatf("sw_hold%0d_valid", i), a_valid, 1);
      check($sformatf("sw_hold%0d_ss", i), a_ss, 2'b10);
      check($sformatf("sw_hold%0d_mem", i), a_mem, 1);
      #1 check($sformatf("sw_hold%0d_stall", i), a_stall, 1);
      tick();
    end
    redirect = 1'b0;
    mem_ready = 1'b1;
    check("sw_last_mem", a_mem, 1);
    check("sw_last_ss", a_ss, 2'b10);
    #1 check("sw_release_stall", a_stall, 0);
    tick();
    check("addi_rd", a_rd, 7);
    check("addi_valid", a_valid, 1);
    check("addi_mem", a_mem, 0);

    // Multiply: MUL_LAT=4 instance holds three cycles, the other never stalls
    drive("MUL x8", 1'b1, 7'b0110011, 3'b000, 3'b110, 1'b1, 5'd1, 5'd2, 5'd8);
    #1 check("mul_enter_stall_m", m_stall, 0);
    tick();
    check("mul_ex_mul_m", m_mul, 1);
    check("mul_ex_mul_a", a_mul, 0);
    drive("ADDI x9", 1'b1, 7'b0010011, 3'b000, 3'b100, 1'b0, 5'd1, 5'd0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mul_hold%0d_stall_m", i), m_stall, 1);
      check($sformatf("mul_hold%0d_stall_a", i), a_stall, 0);
      check($sformatf("mul_hold%0d_rd_m", i), m_rd, 8);
      tick();
    end
    #1 check("mul_release_stall_m", m_stall, 0);
    tick();
    check("mul_next_rd_m", m_rd, 9);
    check("mul_next_mul_m", m_mul, 0);

    // Redirect coinciding with a load-use hazard
    drive("LW x10", 1'b1, 7'b0000011, 3'b010, 3'b100, 1'b0, 5'd1, 5'd0, 5'd10);
    tick();
    drive("ADD x11", 1'b1, 7'b0110011, 3'b000, 3'b110, 1'b0, 5'd10, 5'd0, 5'd11);
    redirect = 1'b1;
    #1 check("redir_stall", a_stall, 0);
    tick();
    redirect = 1'b0;
    check("redir_valid", a_valid, 0);

    // Load to x0 never creates a hazard
    drive("LW x0", 1'b1, 7'b0000011, 3'b010, 3'b100, 1'b0, 5'd1, 5'd0, 5'd0);
    tick();
    drive("ADD x12", 1'b1, 7'b0110011, 3'b000, 3'b110, 1'b0, 5'd0, 5'd0, 5'd12);
    #1 check("x0_stall", a_stall, 0);
    tick();
    check("x0_valid", a_valid, 1);
    check("x0_rd", a_rd, 12);

    // Reset asserted in the middle of a memory wait
    drive("LW x13", 1'b1, 7'b0000011, 3'b010, 3'b100, 1'b0, 5'd1, 5'd0, 5'd13);
    mem_ready = 1'b0;
    tick();
    #1 check("midrst_wait_stall", a_stall, 1);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    drive("ADDI x14", 1'b1, 7'b0010011, 3'b000, 3'b100, 1'b0, 5'd1, 5'd0, 5'd14);
    check("midrst_valid", a_valid, 0);
    check("midrst_mem", a_mem, 0);
    #1 check("midrst_stall", a_stall, 0);
    tick();
    check("midrst_next_valid", a_valid, 1);
    check("midrst_next_rd", a_rd, 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
